// File: rtl/shift_pkg.sv
// Shared constants, control struct and decode helper for the execute-stage shift unit.
package shift_pkg;

  // funct3 encodings for RV32I shift instructions
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  // funct7 encodings (imm[11:5] for immediate forms)
  localparam logic [6:0] F7_LOGIC = 7'b0000000;
  localparam logic [6:0] F7_ARITH = 7'b0100000;

  // Controls handed to the barrel shifter plus the illegal-encoding flag
  typedef struct packed {
    logic left1_right0;
    logic arith1_logic0;
    logic shift1_rotate0;
    logic illegal;
  } shift_ctrl_t;

  // Canned control words. The illegal word still asks for a plain shift so
  // rotate mode can never be reached from this block.
  localparam shift_ctrl_t CTRL_SLL     = '{left1_right0: 1'b1, arith1_logic0: 1'b0,
                                           shift1_rotate0: 1'b1, illegal: 1'b0};
  localparam shift_ctrl_t CTRL_SRL     = '{left1_right0: 1'b0, arith1_logic0: 1'b0,
                                           shift1_rotate0: 1'b1, illegal: 1'b0};
  localparam shift_ctrl_t CTRL_SRA     = '{left1_right0: 1'b0, arith1_logic0: 1'b1,
                                           shift1_rotate0: 1'b1, illegal: 1'b0};
  localparam shift_ctrl_t CTRL_ILLEGAL = '{left1_right0: 1'b0, arith1_logic0: 1'b0,
                                           shift1_rotate0: 1'b1, illegal: 1'b1};

  // Map funct3/funct7 onto shifter controls; anything unrecognised is illegal
  function automatic shift_ctrl_t decode_shift(input logic [2:0] funct3,
                                               input logic [6:0] funct7);
    shift_ctrl_t ctrl;
    ctrl = CTRL_ILLEGAL;
    case (funct3)
      F3_SLL: begin
        if (funct7 == F7_LOGIC) begin
          ctrl = CTRL_SLL;
        end else begin
          ctrl = CTRL_ILLEGAL;
        end
      end
      F3_SR: begin
        case (funct7)
          F7_LOGIC: ctrl = CTRL_SRL;
          F7_ARITH: ctrl = CTRL_SRA;
          default:  ctrl = CTRL_ILLEGAL;
        endcase
      end
      default: ctrl = CTRL_ILLEGAL;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/shift_exec_stage_if.sv
// Issue-side and writeback-side handshake bundle of the shift execute stage.
interface shift_exec_stage_if #(
  parameter int BitWidth = 32
);
  localparam int AmtWidth = $clog2(BitWidth);

  // issue -> stage
  logic                in_valid;
  logic                in_ready;
  logic [2:0]          in_funct3;
  logic [6:0]          in_funct7;
  logic                in_is_imm;
  logic [BitWidth-1:0] in_rs1;
  logic [BitWidth-1:0] in_rs2;
  logic [AmtWidth-1:0] in_shamt;
  logic [4:0]          in_rd;

  // stage -> writeback
  logic                out_valid;
  logic                out_ready;
  logic [BitWidth-1:0] out_result;
  logic [4:0]          out_rd;
  logic                out_illegal;

  // Environment side: drives ops in and the writeback ready
  modport master (
    output in_valid, in_funct3, in_funct7, in_is_imm, in_rs1, in_rs2, in_shamt, in_rd,
    output out_ready,
    input  in_ready,
    input  out_valid, out_result, out_rd, out_illegal
  );

  // Stage side
  modport slave (
    input  in_valid, in_funct3, in_funct7, in_is_imm, in_rs1, in_rs2, in_shamt, in_rd,
    input  out_ready,
    output in_ready,
    output out_valid, out_result, out_rd, out_illegal
  );

endinterface

// File: rtl/barrel_shifter.sv
// Combinational logarithmic barrel shifter: left/right, logical/arithmetic, shift/rotate.
module barrel_shifter #(
  parameter int BitWidth = 32
) (
  input  logic [BitWidth-1:0]         i_data,
  input  logic [$clog2(BitWidth)-1:0] i_amt,
  input  logic                        i_left1_right0,
  input  logic                        i_arith1_logic0,
  input  logic                        i_shift1_rotate0,
  output logic [BitWidth-1:0]         o_result
);
  localparam int AmtWidth = $clog2(BitWidth);

  logic [BitWidth-1:0] w_acc;

  // One conditional power-of-two step per amount bit
  always_comb begin
    w_acc = i_data;
    for (int k = 0; k < AmtWidth; k++) begin
      if (i_amt[k]) begin
        if (i_left1_right0) begin
          if (i_shift1_rotate0) begin
            w_acc = w_acc << (1 << k);
          end else begin
            w_acc = (w_acc << (1 << k)) | (w_acc >> (BitWidth - (1 << k)));
          end
        end else begin
          if (!i_shift1_rotate0) begin
            w_acc = (w_acc >> (1 << k)) | (w_acc << (BitWidth - (1 << k)));
          end else if (i_arith1_logic0) begin
            w_acc = $unsigned($signed(w_acc) >>> (1 << k));
          end else begin
            w_acc = w_acc >> (1 << k);
          end
        end
      end else begin
        w_acc = w_acc;
      end
    end
  end

  assign o_result = w_acc;

endmodule

// File: rtl/shift_exec_stage.sv
// RV32I execute-stage shift unit: decode in front of S1, barrel shifter between
// S1 and S2, outputs straight from the S2 registers.
module shift_exec_stage
  import shift_pkg::*;
#(
  parameter int BitWidth = 32
) (
  input logic               clk,
  input logic               rst,
  input logic               flush,
  shift_exec_stage_if.slave bus
);
  localparam int AmtWidth = $clog2(BitWidth);

  // Decode / handshake wires
  shift_ctrl_t         w_dec;
  logic [AmtWidth-1:0] w_amt;
  logic                w_s2_advance;
  logic                w_s1_advance;
  logic                w_in_ready;
  logic                w_accept;
  logic [BitWidth-1:0] w_shifted;
  logic [BitWidth-1:0] w_s2_result;

  // Stage 1 registers
  logic                r_s1_valid;
  shift_ctrl_t         r_s1_ctrl;
  logic [AmtWidth-1:0] r_s1_amt;
  logic [BitWidth-1:0] r_s1_rs1;
  logic [4:0]          r_s1_rd;

  // Stage 2 registers (drive the outputs)
  logic                r_s2_valid;
  logic [BitWidth-1:0] r_s2_result;
  logic [4:0]          r_s2_rd;
  logic                r_s2_illegal;

  // Decode the incoming op and pick the architectural mod-BitWidth amount
  always_comb begin
    w_dec = decode_shift(bus.in_funct3, bus.in_funct7);
    if (bus.in_is_imm) begin
      w_amt = bus.in_shamt;
    end else begin
      w_amt = bus.in_rs2[AmtWidth-1:0];
    end
  end

  // S2 moves when empty or drained; S1 moves with S2, or fills when empty
  assign w_s2_advance = !r_s2_valid || bus.out_ready;
  assign w_s1_advance = !r_s1_valid || w_s2_advance;
  assign w_in_ready   = !rst && !flush && w_s1_advance;
  assign w_accept     = bus.in_valid && w_in_ready;

  // Stage 1: capture decoded controls, amount and operands on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_ctrl  <= '{left1_right0: 1'b0, arith1_logic0: 1'b0,
                      shift1_rotate0: 1'b0, illegal: 1'b0};
      r_s1_amt   <= {AmtWidth{1'b0}};
      r_s1_rs1   <= {BitWidth{1'b0}};
      r_s1_rd    <= 5'd0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_advance) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_ctrl <= w_dec;
        r_s1_amt  <= w_amt;
        r_s1_rs1  <= bus.in_rs1;
        r_s1_rd   <= bus.in_rd;
      end
    end
  end

  barrel_shifter #(
    .BitWidth(BitWidth)
  ) bs (
    .i_data          (r_s1_rs1),
    .i_amt           (r_s1_amt),
    .i_left1_right0  (r_s1_ctrl.left1_right0),
    .i_arith1_logic0 (r_s1_ctrl.arith1_logic0),
    .i_shift1_rotate0(r_s1_ctrl.shift1_rotate0),
    .o_result        (w_shifted)
  );

  // Illegal encodings carry a zero result down the pipe
  always_comb begin
    if (r_s1_ctrl.illegal) begin
      w_s2_result = {BitWidth{1'b0}};
    end else begin
      w_s2_result = w_shifted;
    end
  end

  // Stage 2: capture the shifter output; hold everything while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid   <= 1'b0;
      r_s2_result  <= {BitWidth{1'b0}};
      r_s2_rd      <= 5'd0;
      r_s2_illegal <= 1'b0;
    end else if (flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_advance) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_result  <= w_s2_result;
        r_s2_rd      <= r_s1_rd;
        r_s2_illegal <= r_s1_ctrl.illegal;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_s2_valid;
  assign bus.out_result  = r_s2_result;
  assign bus.out_rd      = r_s2_rd;
  assign bus.out_illegal = r_s2_illegal;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed self-checking bench for shift_exec_stage.
module tb_shift_exec_stage;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  shift_exec_stage_if #(.BitWidth(32)) bus ();

  shift_exec_stage #(.BitWidth(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus.slave)
  );

  // Put an op's fields on the issue bus (in_valid handled by the caller)
  task automatic set_op(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [4:0] shamt, input logic [4:0] rd);
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_is_imm = imm;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_shamt  = shamt;
    bus.in_rd     = rd;
  endtask

  // Issue one op into an idle pipe and wait (bounded) for its result.
  // lat = rising edges from first presenting the op to out_valid; -1 on timeout.
  task automatic exec_op(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [4:0] shamt, input logic [4:0] rd,
                         output logic [31:0] o_res, output logic [4:0] o_rd,
                         output logic o_ill, output int lat);
    set_op(f3, f7, imm, rs1, rs2, shamt, rd);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    o_res = bus.out_result;
    o_rd  = bus.out_rd;
    o_ill = bus.out_illegal;
    if (!bus.out_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    set_op(3'b000, 7'd0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
    n_tests++; if (bus.out_result !== 32'h0) begin n_fail++; $display("FAIL reset_out_result: got %h, expected 0", bus.out_result); end
    n_tests++; if (bus.out_rd !== 5'd0) begin n_fail++; $display("FAIL reset_out_rd: got %0d, expected 0", bus.out_rd); end
    n_tests++; if (bus.out_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_out_illegal: got %b, expected 0", bus.out_illegal); end
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low: got %b, expected 0", bus.in_ready); end
    rst = 1'b0;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b, expected 1", bus.in_ready); end
    @(posedge clk);
    #1;
    n_tests++; if (bus.out_valid !== 1'b0 || bus.out_result !== 32'h0) begin n_fail++; $display("FAIL post_reset_outputs: got valid=%b result=%h, expected 0/0", bus.out_valid, bus.out_result); end
  endtask

  task automatic test_sll_reg();
    logic [31:0] res; logic [4:0] rd; logic ill; int lat;
    exec_op(F3_SLL, F7_LOGIC, 1'b0, 32'h0000000A, 32'h00000003, 5'd0, 5'd5, res, rd, ill, lat);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL sll_latency: got %0d, expected 2", lat); end
    n_tests++; if (res !== 32'h00000050) begin n_fail++; $display("FAIL sll_result: got %h, expected 00000050", res); end
    n_tests++; if (rd !== 5'd5) begin n_fail++; $display("FAIL sll_rd: got %0d, expected 5", rd); end
    n_tests++; if (ill !== 1'b0) begin n_fail++; $display("FAIL sll_illegal: got %b, expected 0", ill); end
  endtask

  task automatic test_shift_imm();
    logic [31:0] res; logic [4:0] rd; logic ill; int lat;
    // rs2 holds a different amount to prove the immediate is used
    exec_op(F3_SR, F7_ARITH, 1'b1, 32'hA0000000, 32'h0000001F, 5'd4, 5'd6, res, rd, ill, lat);
    n_tests++; if (res !== 32'hFA000000 || lat != 2) begin n_fail++; $display("FAIL srai: got %h lat %0d, expected FA000000 lat 2", res, lat); end
    exec_op(F3_SR, F7_LOGIC, 1'b1, 32'hA0000000, 32'h0000001F, 5'd4, 5'd7, res, rd, ill, lat);
    n_tests++; if (res !== 32'h0A000000 || rd !== 5'd7) begin n_fail++; $display("FAIL srli: got %h rd %0d, expected 0A000000 rd 7", res, rd); end
  endtask

  task automatic test_amount_mask();
    logic [31:0] res; logic [4:0] rd; logic ill; int lat;
    exec_op(F3_SLL, F7_LOGIC, 1'b0, 32'h00000001, 32'hFFFFFF21, 5'd0, 5'd1, res, rd, ill, lat);
    n_tests++; if (res !== 32'h00000002) begin n_fail++; $display("FAIL mask_sll: got %h, expected 00000002", res); end
    exec_op(F3_SLL, F7_LOGIC, 1'b0, 32'h80000001, 32'h00000020, 5'd0, 5'd2, res, rd, ill, lat);
    n_tests++; if (res !== 32'h80000001) begin n_fail++; $display("FAIL zero_sll: got %h, expected 80000001", res); end
    exec_op(F3_SR, F7_LOGIC, 1'b1, 32'h80000001, 32'h00000005, 5'd0, 5'd3, res, rd, ill, lat);
    n_tests++; if (res !== 32'h80000001) begin n_fail++; $display("FAIL zero_srl: got %h, expected 80000001", res); end
    exec_op(F3_SR, F7_ARITH, 1'b0, 32'h80000001, 32'hFFFFFFE0, 5'd0, 5'd4, res, rd, ill, lat);
    n_tests++; if (res !== 32'h80000001) begin n_fail++; $display("FAIL zero_sra: got %h, expected 80000001", res); end
  endtask

  task automatic test_illegal();
    logic [31:0] res; logic [4:0] rd; logic ill; int lat;
    exec_op(F3_SLL, F7_ARITH, 1'b0, 32'h12345678, 32'h00000004, 5'd0, 5'd8, res, rd, ill, lat);
    n_tests++; if (ill !== 1'b1 || res !== 32'h0 || lat != 2) begin n_fail++; $display("FAIL illegal_sll_f7: got ill=%b res=%h lat=%0d, expected 1/0/2", ill, res, lat); end
    exec_op(F3_SR, 7'b0000001, 1'b0, 32'h12345678, 32'h00000004, 5'd0, 5'd9, res, rd, ill, lat);
    n_tests++; if (ill !== 1'b1 || res !== 32'h0 || lat != 2 || rd !== 5'd9) begin n_fail++; $display("FAIL illegal_sr_f7: got ill=%b res=%h lat=%0d rd=%0d, expected 1/0/2/9", ill, res, lat, rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_res [3] = '{32'h00000002, 32'h00000004, 32'h00000008};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        set_op(F3_SLL, F7_LOGIC, 1'b1, 32'h00000001, 32'h0, 5'(i + 1), 5'(10 + i));
        bus.in_valid = 1'b1;
        #1;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b, expected 1", i, bus.in_ready); end
      end else begin
        bus.in_valid = 1'b0;
        #1;
      end
      if (i >= 2) begin
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== exp_res[i-2] || bus.out_rd !== 5'(8 + i)) begin
          n_fail++; $display("FAIL b2b_out[%0d]: got v=%b res=%h rd=%0d, expected 1/%h/%0d", i - 2, bus.out_valid, bus.out_result, bus.out_rd, exp_res[i-2], 8 + i);
        end
      end else if (i == 1) begin
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early_valid: got %b, expected 0", bus.out_valid); end
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_res [4] = '{32'h78000000, 32'h3C000000, 32'h1E000000, 32'h0F000000};
    int idx = 0;
    int got = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [31:0] prev_res = 32'h0;
    logic [4:0] prev_rd = 5'd0;
    logic fire_in, fire_out;
    while (got < 4 && cyc < 40) begin
      bus.out_ready = (cyc >= 4);
      if (idx < 4) begin
        set_op(F3_SR, F7_LOGIC, 1'b0, 32'hF0000000, 32'(idx + 1), 5'd0, 5'(20 + idx));
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      fire_in  = bus.in_valid && bus.in_ready;
      fire_out = bus.out_valid && bus.out_ready;
      if (stalled) begin
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== prev_res || bus.out_rd !== prev_rd) begin
          n_fail++; $display("FAIL bp_stable[cyc %0d]: got v=%b res=%h rd=%0d, expected 1/%h/%0d", cyc, bus.out_valid, bus.out_result, bus.out_rd, prev_res, prev_rd);
        end
      end
      if (cyc == 2 || cyc == 3) begin
        n_tests++;
        if (bus.in_ready !== 1'b0 || idx != 2) begin
          n_fail++; $display("FAIL bp_in_ready[cyc %0d]: got in_ready=%b accepts=%0d, expected 0/2", cyc, bus.in_ready, idx);
        end
      end
      if (fire_out) begin
        n_tests++;
        if (bus.out_result !== exp_res[got] || bus.out_rd !== 5'(20 + got)) begin
          n_fail++; $display("FAIL bp_order[%0d]: got res=%h rd=%0d, expected %h/%0d", got, bus.out_result, bus.out_rd, exp_res[got], 20 + got);
        end
        got++;
      end
      if (fire_in) idx++;
      stalled  = bus.out_valid && !bus.out_ready;
      prev_res = bus.out_result;
      prev_rd  = bus.out_rd;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    n_tests++; if (got != 4 || idx != 4) begin n_fail++; $display("FAIL bp_count: got %0d results %0d accepts, expected 4/4", got, idx); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b1;
    set_op(F3_SLL, F7_LOGIC, 1'b0, 32'h1, 32'h1, 5'd0, 5'd1);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    set_op(F3_SLL, F7_LOGIC, 1'b0, 32'h1, 32'h2, 5'd0, 5'd2);
    @(posedge clk); #1;
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_setup: got out_valid=%b, expected 1", bus.out_valid); end
    flush = 1'b1;
    set_op(F3_SLL, F7_LOGIC, 1'b0, 32'h1, 32'h3, 5'd0, 5'd3);
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b, expected 0", bus.in_ready); end
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b, expected 0", bus.out_valid); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak[%0d]: got out_valid=%b, expected 0", i, bus.out_valid); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; logic [4:0] rd; logic ill; int lat;
    bus.out_ready = 1'b1;
    set_op(F3_SLL, F7_LOGIC, 1'b0, 32'h1, 32'h1, 5'd0, 5'd11);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    set_op(F3_SLL, F7_LOGIC, 1'b0, 32'h1, 32'h2, 5'd0, 5'd12);
    @(posedge clk); #1;
    rst = 1'b1;
    set_op(F3_SLL, F7_LOGIC, 1'b0, 32'h1, 32'h3, 5'd0, 5'd13);
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_ready: got %b, expected 0", bus.in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_result !== 32'h0 || bus.out_rd !== 5'd0 || bus.out_illegal !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_outputs: got v=%b res=%h rd=%0d ill=%b, expected all 0", bus.out_valid, bus.out_result, bus.out_rd, bus.out_illegal);
    end
    exec_op(F3_SR, F7_ARITH, 1'b0, 32'h80000000, 32'h00000001, 5'd0, 5'd7, res, rd, ill, lat);
    n_tests++; if (res !== 32'hC0000000 || rd !== 5'd7 || lat != 2) begin n_fail++; $display("FAIL rstmid_recover: got res=%h rd=%0d lat=%0d, expected C0000000/7/2", res, rd, lat); end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    set_op(3'b000, 7'd0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    test_reset();
    test_sll_reg();
    test_shift_imm();
    test_amount_mask();
    test_illegal();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_exec_stage.md
# shift_exec_stage

Execute-stage shift unit for the RV32I core. It accepts decoded shift instructions from issue, selects and masks the shift amount, and maps funct3/funct7 onto the `barrel_shifter` controls. It returns the result to writeback through a two-stage valid/ready pipeline. Only this block drives the barrel shifter; writeback consumes its output.

## Interface
- `BitWidth`, 32, datapath width; must be a power of two.
- `AmtWidth`, `$clog2(BitWidth)`, shift-amount width; localparam, not overridable.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  synchronous kill of all in-flight ops (branch mispredict).
- `in_valid`  in  1  issue presents an op.
- `in_ready`  out  1  stage can accept; transfer occurs when `in_valid && in_ready` at a rising edge.
- `in_funct3`  in  3  instruction funct3.
- `in_funct7`  in  7  instruction funct7 (imm[11:5] for immediate forms).
- `in_is_imm`  in  1  1 = SLLI/SRLI/SRAI; 0 = register form.
- `in_rs1`  in  BitWidth  value to shift.
- `in_rs2`  in  BitWidth  register-form amount source.
- `in_shamt`  in  AmtWidth  immediate amount (imm[4:0]).
- `in_rd`  in  5  destination register tag.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  writeback accepts; transfer occurs when `out_valid && out_ready`.
- `out_result`  out  BitWidth  shifted value.
- `out_rd`  out  5  destination tag, carried unchanged.
- `out_illegal`  out  1  encoding was not a legal shift.

## Operation
- Decode:
  - funct3 001, funct7 0000000 → SLL: `left1_right0`=1, `arith1_logic0`=0, `shift1_rotate0`=1.
  - funct3 101, funct7 0000000 → SRL: `left1_right0`=0, `arith1_logic0`=0, `shift1_rotate0`=1.
  - funct3 101, funct7 0100000 → SRA: `left1_right0`=0, `arith1_logic0`=1, `shift1_rotate0`=1.
- Any other funct3/funct7 combination is illegal. An illegal op still flows through the pipeline with `out_illegal`=1 and `out_result`=0.
- Amount: `in_is_imm` ? `in_shamt` : `in_rs2[AmtWidth-1:0]`. Upper bits of rs2 are ignored; this is the architectural mod-32 rule.
- Stage 1 (S1) registers the decoded controls, the amount, rs1, rd and the illegal flag. No decode logic runs after S1.
- The barrel shifter is combinational, sitting between S1 and S2.
- Stage 2 (S2) registers the shifter output, rd and the illegal flag. The `out_*` ports are driven directly from the S2 registers.
- Each stage holds its contents until it advances.
  - S2 advances when empty or `out_ready`=1.
  - S1 advances when S2 advances.
- `in_ready` = !rst && !flush && (!S1_valid || S2 advances). This is combinational, with no dependence on `in_valid`.
- Order is strictly preserved. Ops are never dropped or duplicated except by flush or reset.

## Timing
- Reset, and the first cycle after reset: S1/S2 valid=0, `out_valid`=0, `out_result`=0, `out_rd`=0, `out_illegal`=0. Data registers are also cleared.
- Latency: an op accepted at edge N has `out_valid`=1 after edge N+2, provided `out_ready` was high.
- Throughput: one op per cycle while `out_ready`=1.
- Backpressure with `out_ready`=0:
  - S2 holds its values stable.
  - S1 fills.
  - `in_ready` falls once both stages are valid.
  - At most 2 ops are buffered.
- `out_*` must not change while `out_valid && !out_ready`.
- Flush:
  - At the flush edge, both valid bits clear.
  - `in_ready`=0 during the flush cycle, so an `in_valid` presented in that cycle is not accepted.
  - If `out_ready`=1 in the flush cycle, the S2 transfer still counts as accepted by writeback.
- Reset mid-operation: identical to flush, and all outputs return to their reset values.
- Amount 0 in every mode: `out_result` = rs1.

## Structure
- `shift_pkg` holds:
  - the funct3 constants `F3_SLL`=3'b001 and `F3_SR`=3'b101;
  - the funct7 constants `F7_LOGIC`=7'b0000000 and `F7_ARITH`=7'b0100000;
  - the `shift_ctrl_t` packed struct {left1_right0, arith1_logic0, shift1_rotate0, illegal}.
- One sub-module: the existing `barrel_shifter` (`BitWidth` passed through), instantiated as `bs`. Rotate mode is never selected by this block.

## Test plan
- Register SLL: rs1=0x0000000A, rs2=0x00000003, rd=5 → two edges after accept, `out_result`=0x00000050, `out_rd`=5, `out_illegal`=0.
- SRAI/SRLI: rs1=0xA0000000, shamt=4, funct7=0100000 → 0xFA000000; same op with funct7=0000000 → 0x0A000000.
- Amount masking: SLL with rs1=0x00000001, rs2=0xFFFFFF21 → 0x00000002. Amount 0 on rs1=0x80000001 in SLL, SRL and SRA → 0x80000001 each time.
- Backpressure: issue 4 back-to-back ops with `out_ready`=0 for 4 cycles → `in_ready` drops after 2 accepts, S2 outputs stay stable, all 4 results emerge in order with none lost.
- Illegal encodings: funct3=001 with funct7=0100000, and funct3=101 with funct7=0000001 → `out_illegal`=1, `out_result`=0, latency unchanged.
- Flush with 2 ops in flight plus `in_valid` high in the flush cycle → `out_valid`=0 on the next cycle and the new op is not accepted. Repeat with `rst` → all outputs read 0 and a following op completes normally in 2 cycles.
